// File: rtl/vend_ctrl_multi.sv
// vend_ctrl_multi: multi-item vending controller.
// Accepts four coin denominations, sells one of N_ITEMS products priced
// BASE_PRICE + i*PRICE_STEP, tracks per-item stock and pays change back
// greedily, one coin per ready/valid handshake with the hopper.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   coin_valid, coin_sel  coin inserted pulse and its denomination code
//   sel_valid, sel_item   product selection pulse and index
//   cancel                refund all credit
//   restock_valid/_item   reload one item's stock to STOCK_INIT
//   chg_ready             hopper accepts the presented change coin
//   vend, vend_item       one-cycle dispense pulse and dispensed item
//   chg_valid, chg_coin   change coin presented to the hopper
//   coin_reject           inserted coin returned uncounted
//   err_funds, err_soldout selection error pulses
//   credit                current credit (feeds the display)
//   busy                  controller not in IDLE
//   stock_empty           bit i set when item i is out of stock
module vend_ctrl_multi #(
  parameter int N_ITEMS    = 4,
  parameter int ITEM_W     = 2,
  parameter int CREDIT_W   = 8,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 3,
  parameter int COIN0      = 1,
  parameter int COIN1      = 2,
  parameter int COIN2      = 5,
  parameter int COIN3      = 10,
  parameter int BASE_PRICE = 15,
  parameter int PRICE_STEP = 5,
  parameter int MAX_CREDIT = 50
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_sel,
  input  logic                sel_valid,
  input  logic [ITEM_W-1:0]   sel_item,
  input  logic                cancel,
  input  logic                restock_valid,
  input  logic [ITEM_W-1:0]   restock_item,
  input  logic                chg_ready,
  output logic                vend,
  output logic [ITEM_W-1:0]   vend_item,
  output logic                chg_valid,
  output logic [1:0]          chg_coin,
  output logic                coin_reject,
  output logic                err_funds,
  output logic                err_soldout,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic [N_ITEMS-1:0]  stock_empty
);

  // One extra bit so credit+coin and credit-price never wrap.
  localparam int AW = CREDIT_W + 1;

  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

  state_t             state;
  logic [STOCK_W-1:0] stock [N_ITEMS];

  logic [AW-1:0] credit_x;
  logic [AW-1:0] add_sum;
  logic [AW-1:0] sel_price;
  logic [AW-1:0] chg_rem;
  logic          sel_in_range;
  logic          sel_soldout;

  function automatic logic [AW-1:0] coin_value(input logic [1:0] code);
    logic [AW-1:0] v;
    case (code)
      2'd0:    v = AW'(COIN0);
      2'd1:    v = AW'(COIN1);
      2'd2:    v = AW'(COIN2);
      default: v = AW'(COIN3);
    endcase
    return v;
  endfunction

  // Largest denomination not exceeding c; COIN0 is 1 so code 0 always fits.
  function automatic logic [1:0] greedy(input logic [AW-1:0] c);
    logic [1:0] g;
    if (c >= coin_value(2'd3))      g = 2'd3;
    else if (c >= coin_value(2'd2)) g = 2'd2;
    else if (c >= coin_value(2'd1)) g = 2'd1;
    else                            g = 2'd0;
    return g;
  endfunction

  always_comb begin
    credit_x     = {1'b0, credit};
    add_sum      = credit_x + coin_value(coin_sel);
    sel_price    = AW'(BASE_PRICE) + AW'(PRICE_STEP) * AW'(sel_item);
    chg_rem      = credit_x - coin_value(chg_coin);
    sel_in_range = 32'(sel_item) < N_ITEMS;
    sel_soldout  = 1'b1;
    if (sel_in_range) sel_soldout = (stock[sel_item] == '0);
  end

  always_comb begin
    stock_empty = '0;
    for (int unsigned i = 0; i < N_ITEMS; i++) stock_empty[i] = (stock[i] == '0);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      credit      <= '0;
      vend        <= 1'b0;
      vend_item   <= '0;
      chg_valid   <= 1'b0;
      chg_coin    <= '0;
      coin_reject <= 1'b0;
      err_funds   <= 1'b0;
      err_soldout <= 1'b0;
      for (int unsigned i = 0; i < N_ITEMS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      vend        <= 1'b0;
      coin_reject <= 1'b0;
      err_funds   <= 1'b0;
      err_soldout <= 1'b0;
      case (state)
        IDLE: begin
          if (cancel) begin
            coin_reject <= coin_valid;
            if (credit != '0) begin
              state     <= CHANGE;
              chg_valid <= 1'b1;
              chg_coin  <= greedy(credit_x);
            end
          end else if (sel_valid) begin
            coin_reject <= coin_valid;
            if (sel_soldout) begin
              err_soldout <= 1'b1;
            end else if (credit_x < sel_price) begin
              err_funds <= 1'b1;
            end else begin
              credit           <= CREDIT_W'(credit_x - sel_price);
              stock[sel_item]  <= stock[sel_item] - STOCK_W'(1);
              vend_item        <= sel_item;
              vend             <= 1'b1;
              state            <= VEND;
            end
          end else if (coin_valid) begin
            if (add_sum <= AW'(MAX_CREDIT)) credit <= CREDIT_W'(add_sum);
            else                            coin_reject <= 1'b1;
          end
        end
        VEND: begin
          coin_reject <= coin_valid;
          if (credit != '0) begin
            state     <= CHANGE;
            chg_valid <= 1'b1;
            chg_coin  <= greedy(credit_x);
          end else begin
            state <= IDLE;
          end
        end
        CHANGE: begin
          coin_reject <= coin_valid;
          if (chg_ready) begin
            credit <= CREDIT_W'(chg_rem);
            if (chg_rem == '0) begin
              state     <= IDLE;
              chg_valid <= 1'b0;
            end else begin
              chg_coin <= greedy(chg_rem);
            end
          end
        end
        default: state <= IDLE;
      endcase
      // Placed after the FSM so a same-cycle restock overrides a vend decrement.
      if (restock_valid && (32'(restock_item) < N_ITEMS))
        stock[restock_item] <= STOCK_W'(STOCK_INIT);
    end
  end

endmodule

// File: tb/tb_vend_ctrl_multi.sv
module tb_vend_ctrl_multi;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_sel = '0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_item = '0;
  logic       cancel = 1'b0;
  logic       restock_valid = 1'b0;
  logic [1:0] restock_item = '0;
  logic       chg_ready = 1'b0;
  logic       vend;
  logic [1:0] vend_item;
  logic       chg_valid;
  logic [1:0] chg_coin;
  logic       coin_reject;
  logic       err_funds;
  logic       err_soldout;
  logic [7:0] credit;
  logic       busy;
  logic [3:0] stock_empty;

  int checks = 0;
  int errors = 0;

  vend_ctrl_multi #(
    .N_ITEMS(4), .ITEM_W(2), .CREDIT_W(8), .STOCK_W(4), .STOCK_INIT(3),
    .COIN0(1), .COIN1(2), .COIN2(5), .COIN3(10),
    .BASE_PRICE(15), .PRICE_STEP(5), .MAX_CREDIT(50)
  ) dut (
    .clk(clk), .reset(reset),
    .coin_valid(coin_valid), .coin_sel(coin_sel),
    .sel_valid(sel_valid), .sel_item(sel_item),
    .cancel(cancel),
    .restock_valid(restock_valid), .restock_item(restock_item),
    .chg_ready(chg_ready),
    .vend(vend), .vend_item(vend_item),
    .chg_valid(chg_valid), .chg_coin(chg_coin),
    .coin_reject(coin_reject), .err_funds(err_funds), .err_soldout(err_soldout),
    .credit(credit), .busy(busy), .stock_empty(stock_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock: inputs set before the call are sampled at the edge,
  // outputs are read 1 time unit later. Pulse inputs are then cleared.
  task automatic step();
    @(posedge clk);
    #1;
    coin_valid    = 1'b0;
    sel_valid     = 1'b0;
    cancel        = 1'b0;
    restock_valid = 1'b0;
  endtask

  task automatic insert(input logic [1:0] code);
    coin_valid = 1'b1;
    coin_sel   = code;
    step();
  endtask

  // Load exactly 25 credit (from 0), select item 2 and expect a vend.
  task automatic buy2(input string name, input logic with_restock);
    insert(2'd3); insert(2'd3); insert(2'd2);
    sel_valid = 1'b1; sel_item = 2'd2;
    restock_valid = with_restock; restock_item = 2'd2;
    step();
    check(name, {vend, vend_item, credit}, {1'b1, 2'd2, 8'd0});
    step();
  endtask

  task automatic drain();
    chg_ready = 1'b1;
    for (int i = 0; i < 20 && busy; i++) step();
    chg_ready = 1'b0;
    check("drain_idle", {busy, credit}, {1'b0, 8'd0});
  endtask

  // ---------------- reference model ----------------
  int cval[4] = '{1, 2, 5, 10};
  int m_credit;
  int m_stock[4];
  int m_mode;          // 0 idle, 1 dispensing, 2 refunding
  int m_q[$];          // change coins still owed, in payout order
  logic m_vend, m_rej, m_ef, m_es;
  logic [1:0] m_item;

  function automatic void build_refund(input int c);
    m_q.delete();
    for (int d = 3; d >= 0; d--)
      while (c >= cval[d]) begin
        m_q.push_back(d);
        c -= cval[d];
      end
  endfunction

  function automatic void model_reset();
    m_credit = 0;
    foreach (m_stock[i]) m_stock[i] = 3;
    m_mode = 0;
    m_q.delete();
    m_vend = 0; m_rej = 0; m_ef = 0; m_es = 0; m_item = 0;
  endfunction

  function automatic void model_step();
    int price;
    m_vend = 0; m_rej = 0; m_ef = 0; m_es = 0;
    case (m_mode)
      0: begin
        if (cancel) begin
          m_rej = coin_valid;
          if (m_credit > 0) begin build_refund(m_credit); m_mode = 2; end
        end else if (sel_valid) begin
          m_rej = coin_valid;
          price = 15 + 5 * int'(sel_item);
          if (int'(sel_item) >= 4 || m_stock[sel_item] == 0) m_es = 1;
          else if (m_credit < price) m_ef = 1;
          else begin
            m_credit -= price;
            m_stock[sel_item]--;
            m_item = sel_item;
            m_vend = 1;
            m_mode = 1;
          end
        end else if (coin_valid) begin
          if (m_credit + cval[coin_sel] <= 50) m_credit += cval[coin_sel];
          else m_rej = 1;
        end
      end
      1: begin
        m_rej = coin_valid;
        if (m_credit > 0) begin build_refund(m_credit); m_mode = 2; end
        else m_mode = 0;
      end
      default: begin
        m_rej = coin_valid;
        if (chg_ready) begin
          m_credit -= cval[m_q.pop_front()];
          if (m_q.size() == 0) m_mode = 0;
        end
      end
    endcase
    if (restock_valid) m_stock[restock_item] = 3;
  endfunction

  function automatic logic [21:0] model_outputs();
    logic [3:0] e;
    logic [1:0] cc;
    for (int i = 0; i < 4; i++) e[i] = (m_stock[i] == 0);
    cc = (m_mode == 2) ? 2'(m_q[0]) : 2'd0;
    return {m_vend, m_vend ? m_item : 2'd0, m_mode == 2, cc,
            m_rej, m_ef, m_es, 8'(m_credit), m_mode != 0, e};
  endfunction

  function automatic logic [21:0] dut_outputs();
    return {vend, vend ? vend_item : 2'd0, chg_valid, chg_valid ? chg_coin : 2'd0,
            coin_reject, err_funds, err_soldout, credit, busy, stock_empty};
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       cv;
    logic [1:0] cs;
    logic       sv;
    logic [1:0] si;
    logic       cn;
    logic       rdy;
    logic [7:0] e_credit;
    logic       e_vend;
    logic       e_rej;
    logic       e_ef;
    logic       e_es;
    logic       e_cvalid;
    logic [1:0] e_ccoin;
    logic       e_busy;
    logic [3:0] e_empty;
  } vec_t;

  vec_t vt[12];

  initial begin
    logic [1:0] exp_coins[7];
    int rem;

    vt[0]  = '{1, 3, 0, 0, 0, 0, 8'd10, 0, 0, 0, 0, 0, 0, 0, 4'b0};
    vt[1]  = '{1, 3, 0, 0, 0, 0, 8'd20, 0, 0, 0, 0, 0, 0, 0, 4'b0};
    vt[2]  = '{0, 0, 1, 0, 0, 0, 8'd5,  1, 0, 0, 0, 0, 0, 1, 4'b0};
    vt[3]  = '{0, 0, 0, 0, 0, 1, 8'd5,  0, 0, 0, 0, 1, 2, 1, 4'b0};
    vt[4]  = '{0, 0, 0, 0, 0, 1, 8'd0,  0, 0, 0, 0, 0, 0, 0, 4'b0};
    vt[5]  = '{1, 3, 0, 0, 0, 0, 8'd10, 0, 0, 0, 0, 0, 0, 0, 4'b0};
    vt[6]  = '{0, 0, 1, 1, 0, 0, 8'd10, 0, 0, 1, 0, 0, 0, 0, 4'b0};
    vt[7]  = '{0, 0, 0, 0, 0, 0, 8'd10, 0, 0, 0, 0, 0, 0, 0, 4'b0};
    vt[8]  = '{1, 2, 0, 0, 0, 0, 8'd15, 0, 0, 0, 0, 0, 0, 0, 4'b0};
    vt[9]  = '{1, 1, 1, 0, 0, 0, 8'd0,  1, 1, 0, 0, 0, 0, 1, 4'b0};
    vt[10] = '{0, 0, 0, 0, 0, 0, 8'd0,  0, 0, 0, 0, 0, 0, 0, 4'b0};
    vt[11] = '{0, 0, 0, 0, 1, 0, 8'd0,  0, 0, 0, 0, 0, 0, 0, 4'b0};

    // Reset state
    step();
    check("reset_state",
          {vend, vend_item, chg_valid, chg_coin, coin_reject, err_funds, err_soldout, credit, busy, stock_empty},
          {1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 4'b0});
    reset = 1'b0;
    step();

    foreach (vt[i]) begin
      coin_valid = vt[i].cv; coin_sel = vt[i].cs;
      sel_valid  = vt[i].sv; sel_item = vt[i].si;
      cancel     = vt[i].cn; chg_ready = vt[i].rdy;
      step();
      chg_ready = 1'b0;
      check($sformatf("vec%0d", i),
            {vend, vend ? vend_item : 2'd0, chg_valid, chg_valid ? chg_coin : 2'd0,
             coin_reject, err_funds, err_soldout, credit, busy, stock_empty},
            {vt[i].e_vend, 2'd0, vt[i].e_cvalid, vt[i].e_ccoin, vt[i].e_rej,
             vt[i].e_ef, vt[i].e_es, vt[i].e_credit, vt[i].e_busy, vt[i].e_empty});
    end

    // Sell out item 2, then restock it.
    for (int k = 0; k < 3; k++) buy2($sformatf("buy2_%0d", k), 1'b0);
    check("soldout_flag", stock_empty, 4'b0100);
    insert(2'd3); insert(2'd3); insert(2'd2);
    sel_valid = 1'b1; sel_item = 2'd2;
    step();
    check("soldout_pulse", {err_soldout, vend, err_funds, credit}, {1'b1, 1'b0, 1'b0, 8'd25});
    cancel = 1'b1;
    step();
    drain();
    restock_valid = 1'b1; restock_item = 2'd2;
    step();
    check("restock_clears", stock_empty, 4'b0000);

    // Restock in the same cycle as a vend decrement: restock must win.
    buy2("rw_pre0", 1'b0);
    buy2("rw_pre1", 1'b0);
    buy2("rw_same", 1'b1);
    buy2("rw_post0", 1'b0);
    buy2("rw_post1", 1'b0);
    buy2("rw_post2", 1'b0);
    check("rw_empty", stock_empty, 4'b0100);

    // Credit ceiling and greedy refund with a slow hopper.
    for (int k = 0; k < 4; k++) insert(2'd3);
    insert(2'd2); insert(2'd1); insert(2'd0);
    check("credit_48", credit, 8'd48);
    insert(2'd2);
    check("over_max_reject", {coin_reject, credit}, {1'b1, 8'd48});
    cancel = 1'b1;
    step();
    exp_coins = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    rem = 48;
    foreach (exp_coins[k]) begin
      for (int j = 0; j < 3; j++) begin
        check($sformatf("chg%0d_%0d", k, j), {chg_valid, chg_coin, credit},
              {1'b1, exp_coins[k], 8'(rem)});
        chg_ready = (j == 2);
        step();
        chg_ready = 1'b0;
      end
      rem -= cval[exp_coins[k]];
    end
    check("refund_done", {chg_valid, busy, credit}, {1'b0, 1'b0, 8'd0});

    // Asynchronous reset in the middle of a refund.
    for (int k = 0; k < 4; k++) insert(2'd3);
    insert(2'd2); insert(2'd1); insert(2'd0);
    cancel = 1'b1;
    step();
    chg_ready = 1'b1;
    step(); step();
    chg_ready = 1'b0;
    check("pre_reset_mid", {chg_valid, credit, stock_empty}, {1'b1, 8'd28, 4'b0100});
    #2 reset = 1'b1;
    #1;
    check("async_reset", {chg_valid, busy, credit, stock_empty, vend},
          {1'b0, 1'b0, 8'd0, 4'b0000, 1'b0});
    step();
    reset = 1'b0;
    step();

    // Randomised run against the reference model.
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      coin_valid    = ($urandom_range(0, 99) < 35);
      coin_sel      = 2'($urandom_range(0, 3));
      sel_valid     = ($urandom_range(0, 99) < 15);
      sel_item      = 2'($urandom_range(0, 3));
      cancel        = ($urandom_range(0, 99) < 5);
      restock_valid = ($urandom_range(0, 99) < 3);
      restock_item  = 2'($urandom_range(0, 3));
      chg_ready     = ($urandom_range(0, 99) < 60);
      model_step();
      step();
      check($sformatf("rand%0d", n), 64'(dut_outputs()), 64'(model_outputs()));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
